// File: rtl/simon_rk_sched.sv
// Round-key scheduler for the Simon 128-bit datapath.
// LOAD writes externally expanded keys into the round-key RAM from address 0.
// RUN streams them back ascending (encrypt) or descending (decrypt). A 2-entry
// FIFO hides the RAM's registered read latency, so a key can be delivered on
// every cycle.
module simon_rk_sched #(
    parameter int AW = 7,
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW:0]   cfg_rounds,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    input  logic          run_start,
    input  logic          run_dec,
    output logic          rk_valid,
    input  logic          rk_ready,
    output logic [DW-1:0] rk_data,
    output logic [AW-1:0] rk_idx,
    output logic          rk_last,
    output logic          run_done,
    output logic          loaded,
    output logic          busy,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_adr,
    output logic [DW-1:0] mem_data_in,
    output logic [AW-1:0] mem_rd_adr,
    input  logic [DW-1:0] mem_dat_out
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READY, S_RUN} state_t;

    // Memory depth expressed in the width of cfg_rounds: 2^AW.
    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    state_t        r_state;
    state_t        w_next;

    logic [AW:0]   r_rounds;         // latched round count T
    logic [AW:0]   r_wr_cnt;         // LOAD write counter
    logic          r_loaded;
    logic          r_dec;
    logic [AW-1:0] r_rd_ptr;         // next index to read
    logic [AW:0]   r_remaining;      // reads still to issue
    logic [AW-1:0] r_rd_adr;         // last issued read address
    logic          r_inflight;       // a read was issued last cycle
    logic [AW-1:0] r_inflight_idx;
    logic          r_inflight_last;
    logic          r_run_done;

    logic [DW-1:0] r_fifo_data [2];
    logic [AW-1:0] r_fifo_idx  [2];
    logic          r_fifo_last [2];
    logic          r_wp;
    logic          r_rp;
    logic [1:0]    r_count;

    logic          w_cfg_ok;
    logic          w_ld_hs;
    logic          w_ld_final;
    logic          w_enter_load;
    logic          w_enter_run;
    logic          w_pop;
    logic          w_pop_last;
    logic          w_push;
    logic [1:0]    w_occ;
    logic          w_issue;

    assign w_cfg_ok     = (cfg_rounds != '0) && (cfg_rounds <= DEPTH);
    assign w_ld_hs      = (r_state == S_LOAD) && ld_valid;
    assign w_ld_final   = w_ld_hs && (r_wr_cnt == r_rounds - 1'b1);
    assign w_enter_load = ((r_state == S_IDLE) || (r_state == S_READY)) && ld_start && w_cfg_ok;
    assign w_enter_run  = (r_state == S_READY) && run_start && !w_enter_load;

    assign w_pop      = rk_valid && rk_ready;
    assign w_pop_last = w_pop && rk_last;
    assign w_push     = r_inflight;
    assign w_occ      = r_count + {1'b0, r_inflight};
    // Issuing on a pop keeps occupancy plus in-flight reads at most 2.
    assign w_issue    = (r_state == S_RUN) && (r_remaining != '0) &&
                        ((w_occ < 2'd2) || w_pop);

    // Outputs
    assign ld_ready    = (r_state == S_LOAD);
    assign busy        = (r_state == S_LOAD) || (r_state == S_RUN);
    assign loaded      = r_loaded;
    assign run_done    = r_run_done;
    assign mem_wr_en   = w_ld_hs;
    assign mem_wr_adr  = r_wr_cnt[AW-1:0];
    assign mem_data_in = ld_data;
    assign mem_rd_adr  = w_issue ? r_rd_ptr : r_rd_adr;
    assign rk_valid    = (r_count != 2'd0);
    assign rk_data     = rk_valid ? r_fifo_data[r_rp] : '0;
    assign rk_idx      = rk_valid ? r_fifo_idx[r_rp]  : '0;
    assign rk_last     = rk_valid && r_fifo_last[r_rp];

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; ld_start takes priority over run_start in READY.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_enter_load) w_next = S_LOAD;
            S_LOAD:  if (w_ld_final)   w_next = S_READY;
            S_READY: begin
                if (w_enter_load)     w_next = S_LOAD;
                else if (w_enter_run) w_next = S_RUN;
            end
            S_RUN:   if (w_pop_last)   w_next = S_READY;
            default: w_next = S_IDLE;
        endcase
    end

    // Load counter, read issue pointer, in-flight tracking and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rounds        <= '0;
            r_wr_cnt        <= '0;
            r_loaded        <= 1'b0;
            r_dec           <= 1'b0;
            r_rd_ptr        <= '0;
            r_remaining     <= '0;
            r_rd_adr        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_idx  <= '0;
            r_inflight_last <= 1'b0;
            r_run_done      <= 1'b0;
            r_wp            <= 1'b0;
            r_rp            <= 1'b0;
            r_count         <= 2'd0;
        end else begin
            if (w_enter_load) begin
                r_rounds <= cfg_rounds;
                r_wr_cnt <= '0;
                r_loaded <= 1'b0;
            end else if (w_ld_hs) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_ld_final) r_loaded <= 1'b1;
            end

            if (w_enter_run) begin
                r_dec       <= run_dec;
                r_rd_ptr    <= run_dec ? (r_rounds[AW-1:0] - 1'b1) : '0;
                r_remaining <= r_rounds;
            end else if (w_issue) begin
                r_rd_ptr    <= r_dec ? (r_rd_ptr - 1'b1) : (r_rd_ptr + 1'b1);
                r_remaining <= r_remaining - 1'b1;
                r_rd_adr    <= r_rd_ptr;
            end

            r_inflight      <= w_issue;
            r_inflight_idx  <= r_rd_ptr;
            r_inflight_last <= (r_remaining == (AW+1)'(1));
            r_run_done      <= w_pop_last;

            if (w_push) r_wp <= ~r_wp;
            if (w_pop)  r_rp <= ~r_rp;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage: captures the RAM data one cycle after the read was issued.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; r_count gates every use, so reset only
        // needs to clear the pointers and the occupancy.
        if (w_push) begin
            r_fifo_data[r_wp] <= mem_dat_out;
            r_fifo_idx[r_wp]  <= r_inflight_idx;
            r_fifo_last[r_wp] <= r_inflight_last;
        end
    end

endmodule

// File: tb/tb_simon_rk_sched.sv
// Self-checking bench for simon_rk_sched with a behavioural 128x64 RAM that
// has a registered read port.
module tb_simon_rk_sched;

    localparam int AW = 7;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [AW:0]   cfg_rounds = '0;
    logic          ld_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_ready;
    logic          run_start = 1'b0;
    logic          run_dec = 1'b0;
    logic          rk_valid;
    logic          rk_ready = 1'b0;
    logic [DW-1:0] rk_data;
    logic [AW-1:0] rk_idx;
    logic          rk_last;
    logic          run_done;
    logic          loaded;
    logic          busy;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_adr;
    logic [DW-1:0] mem_data_in;
    logic [AW-1:0] mem_rd_adr;
    logic [DW-1:0] mem_dat_out = '0;

    logic [DW-1:0] mem [128];
    logic [DW-1:0] seq_ref [128];
    logic [DW-1:0] cur_base;

    int n_checks = 0;
    int n_fail   = 0;

    simon_rk_sched #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst), .cfg_rounds(cfg_rounds),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .run_start(run_start), .run_dec(run_dec),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
        .rk_last(rk_last), .run_done(run_done), .loaded(loaded), .busy(busy),
        .mem_wr_en(mem_wr_en), .mem_wr_adr(mem_wr_adr), .mem_data_in(mem_data_in),
        .mem_rd_adr(mem_rd_adr), .mem_dat_out(mem_dat_out)
    );

    always #5 clk = ~clk;

    // Round-key RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (mem_wr_en) mem[mem_wr_adr] <= mem_data_in;
        mem_dat_out <= mem[mem_rd_adr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " ld_ready"},   64'(ld_ready),   64'd0);
        check({tag, " rk_valid"},   64'(rk_valid),   64'd0);
        check({tag, " rk_last"},    64'(rk_last),    64'd0);
        check({tag, " run_done"},   64'(run_done),   64'd0);
        check({tag, " loaded"},     64'(loaded),     64'd0);
        check({tag, " busy"},       64'(busy),       64'd0);
        check({tag, " mem_wr_en"},  64'(mem_wr_en),  64'd0);
        check({tag, " mem_wr_adr"}, 64'(mem_wr_adr), 64'd0);
        check({tag, " mem_rd_adr"}, 64'(mem_rd_adr), 64'd0);
        check({tag, " rk_idx"},     64'(rk_idx),     64'd0);
        check({tag, " rk_data"},    rk_data,         64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Load t keys base+i; ld_valid toggles every other cycle when toggle=1.
    task automatic do_load(input int t, input logic [63:0] base, input bit toggle, input bit with_run);
        int i = 0;
        int cyc = 0;
        cur_base = base;
        @(negedge clk);
        cfg_rounds = (AW+1)'(t);
        ld_start   = 1'b1;
        run_start  = with_run;
        @(negedge clk);
        ld_start  = 1'b0;
        run_start = 1'b0;
        #1;
        check("load entered ld_ready", 64'(ld_ready), 64'd1);
        check("load entered busy", 64'(busy), 64'd1);
        check("load entered loaded", 64'(loaded), 64'd0);
        while (i < t && cyc < 1000) begin
            ld_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            ld_data  = base + 64'(i);
            #1;
            check("wr_en follows ld_valid", 64'(mem_wr_en), 64'(ld_valid));
            if (ld_valid) begin
                check("wr_adr", 64'(mem_wr_adr), 64'(i));
                check("wr_data", mem_data_in, base + 64'(i));
            end
            @(negedge clk);
            if (ld_valid) i++;
            cyc++;
        end
        ld_valid = 1'b0;
        if (i < t) check("load timeout", 64'(i), 64'(t));
        #1;
        check("after load loaded", 64'(loaded), 64'd1);
        check("after load busy", 64'(busy), 64'd0);
        check("after load ld_ready", 64'(ld_ready), 64'd0);
        check("after load wr_en", 64'(mem_wr_en), 64'd0);
    endtask

    // Run t keys; bp=random rk_ready; lat=check latency/no bubbles;
    // mode 1 stores the sequence, mode 2 compares with the stored one.
    task automatic do_run(input bit dec, input int t, input bit bp, input bit lat, input int mode);
        int beat = 0;
        int cyc = 0;
        int writes = 0;
        int first_valid = -1;
        int last_hs = -1;
        int max_occ = 0;
        bit stalled = 1'b0;
        logic [AW-1:0] held_idx = '0;
        logic [63:0]   held_data = '0;
        logic [AW-1:0] exp_idx;
        @(negedge clk);
        run_start = 1'b1;
        run_dec   = dec;
        rk_ready  = 1'b0;
        @(negedge clk);
        run_start = 1'b0;
        cyc = 1;
        while (beat < t && cyc < 2000) begin
            rk_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (cyc == 1 && lat)
                check("first rd_adr", 64'(mem_rd_adr), dec ? 64'(t - 1) : 64'd0);
            if (mem_wr_en) writes++;
            if (int'(dut.r_count) > max_occ) max_occ = int'(dut.r_count);
            check("run_done quiet during run", 64'(run_done), 64'd0);
            if (rk_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (stalled) begin
                    check("stall idx stable", 64'(rk_idx), 64'(held_idx));
                    check("stall data stable", rk_data, held_data);
                end
                if (rk_ready) begin
                    exp_idx = dec ? AW'(t - 1 - beat) : AW'(beat);
                    check("rk_idx", 64'(rk_idx), 64'(exp_idx));
                    check("rk_data", rk_data, cur_base + 64'(exp_idx));
                    check("rk_last", 64'(rk_last), 64'(beat == t - 1));
                    if (mode == 2) check("rerun same key", rk_data, seq_ref[beat]);
                    if (mode == 1) seq_ref[beat] = rk_data;
                    beat++;
                    last_hs = cyc;
                    stalled = 1'b0;
                end else begin
                    stalled   = 1'b1;
                    held_idx  = rk_idx;
                    held_data = rk_data;
                end
            end
            @(negedge clk);
            cyc++;
        end
        rk_ready = 1'b0;
        if (beat < t) check("run timeout beats", 64'(beat), 64'(t));
        #1;
        check("run_done pulse", 64'(run_done), 64'd1);
        check("after run busy", 64'(busy), 64'd0);
        check("after run loaded", 64'(loaded), 64'd1);
        check("after run rk_valid", 64'(rk_valid), 64'd0);
        if (lat) begin
            check("first rk_valid cycle", 64'(first_valid), 64'd3);
            check("last handshake cycle", 64'(last_hs), 64'(2 + t));
        end
        check("no writes during run", 64'(writes), 64'd0);
        check("fifo occupancy <= 2", 64'(max_occ <= 2), 64'd1);
        @(negedge clk);
        #1;
        check("run_done one cycle", 64'(run_done), 64'd0);
    endtask

    typedef struct {
        logic [AW:0] cfg;
        logic        exp_load;
    } cfg_vec_t;

    cfg_vec_t vecs [6];

    initial begin
        int n;
        int cyc;
        vecs[0] = '{cfg: 8'd0,   exp_load: 1'b0};
        vecs[1] = '{cfg: 8'd129, exp_load: 1'b0};
        vecs[2] = '{cfg: 8'd255, exp_load: 1'b0};
        vecs[3] = '{cfg: 8'd1,   exp_load: 1'b1};
        vecs[4] = '{cfg: 8'd128, exp_load: 1'b1};
        vecs[5] = '{cfg: 8'd68,  exp_load: 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("reset");

        // ld_start legality from IDLE
        for (int v = 0; v < 6; v++) begin
            do_reset();
            cfg_rounds = vecs[v].cfg;
            ld_start   = 1'b1;
            @(negedge clk);
            ld_start = 1'b0;
            #1;
            check("cfg busy", 64'(busy), 64'(vecs[v].exp_load));
            check("cfg ld_ready", 64'(ld_ready), 64'(vecs[v].exp_load));
            @(negedge clk);
            #1;
            check("cfg state held", 64'(busy), 64'(vecs[v].exp_load));
        end

        // run_start in IDLE is ignored
        do_reset();
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("idle run busy", 64'(busy), 64'd0);
            check("idle run rd_adr", 64'(mem_rd_adr), 64'd0);
            check("idle run rk_valid", 64'(rk_valid), 64'd0);
            @(negedge clk);
        end

        // Load 68 keys with toggling valid, encrypt run, re-run, decrypt run
        do_load(68, 64'hA5A5_0000_0000_0000, 1'b1, 1'b0);
        do_run(1'b0, 68, 1'b0, 1'b1, 1);
        do_run(1'b0, 68, 1'b0, 1'b1, 2);
        do_run(1'b1, 68, 1'b1, 1'b0, 0);

        // ld_start and run_start together in READY: load wins
        do_load(68, 64'h1234_0000_0000_0000, 1'b0, 1'b1);
        do_run(1'b1, 68, 1'b0, 1'b0, 0);

        // Depth boundary
        do_load(128, 64'h5A5A_0000_0000_0000, 1'b0, 1'b0);
        do_run(1'b0, 128, 1'b0, 1'b1, 0);
        do_run(1'b1, 128, 1'b1, 1'b0, 0);

        // Reset mid-run after 10 keys of a T=72 run
        do_load(72, 64'hC3C3_0000_0000_0000, 1'b0, 1'b0);
        @(negedge clk);
        run_start = 1'b1;
        run_dec   = 1'b0;
        @(negedge clk);
        run_start = 1'b0;
        rk_ready  = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            #1;
            if (rk_valid) n++;
            @(negedge clk);
            cyc++;
        end
        check("abort keys delivered", 64'(n), 64'd10);
        rst      = 1'b1;
        rk_ready = 1'b0;
        @(negedge clk);
        #1;
        check_idle_outputs("abort");
        rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("abort no run_done", 64'(run_done), 64'd0);
        end
        run_start = 1'b1;
        @(negedge clk);
        run_start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("post-abort run busy", 64'(busy), 64'd0);
            check("post-abort rk_valid", 64'(rk_valid), 64'd0);
            @(negedge clk);
        end

        // Reload then run works again
        do_load(3, 64'h0F0F_0000_0000_0000, 1'b0, 1'b0);
        do_run(1'b1, 3, 1'b0, 1'b1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
